// File: rtl/rpi_irq_pkg.sv
// Shared types and default parameters for the RPi interrupt scheduler.
//   state_e  : scheduler FSM states
//   *_DEF    : default values for N_SRC, TIMEOUT_CYC and HOLDOFF_CYC
//   max_int  : helper used to size the shared cycle counter
package rpi_irq_pkg;

  localparam int N_SRC_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int HOLDOFF_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rpi_irq_sched_if.sv
// Request/grant bundle between the requesters + RPi GPIO and the scheduler.
//   sched_en   : new grants allowed
//   src_req    : per-source request level
//   rpi_ack    : asynchronous acknowledge pin
//   irq_enable : interrupt clock generator enable
//   irq_id     : granted source index
//   pending    : registered pending flags
//   busy       : scheduler not idle
//   err_pulse  : one-cycle ack timeout indication
interface rpi_irq_sched_if
  import rpi_irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
);
  localparam int IDW = $clog2(N_SRC);

  logic             sched_en;
  logic [N_SRC-1:0] src_req;
  logic             rpi_ack;
  logic             irq_enable;
  logic [IDW-1:0]   irq_id;
  logic [N_SRC-1:0] pending;
  logic             busy;
  logic             err_pulse;

  modport master (
    output sched_en, src_req, rpi_ack,
    input  irq_enable, irq_id, pending, busy, err_pulse
  );

  modport slave (
    input  sched_en, src_req, rpi_ack,
    output irq_enable, irq_id, pending, busy, err_pulse
  );

endinterface

// File: rtl/rpi_ack_sync.sv
// Brings the asynchronous RPi acknowledge into clk_in and flags its rising edge.
//   clk_in : system clock
//   rst_n  : asynchronous active-low reset
//   ack_i  : raw acknowledge pin
//   rise_o : high for one cycle when the synchronized ack goes 0 -> 1
// A pin rise sampled at edge n is visible on rise_o after edge n+1 and is
// therefore consumed by the scheduler at edge n+2.
module rpi_ack_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic ack_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= ack_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/rpi_irq_sched.sv
// Round-robin interrupt scheduler toward a Raspberry Pi GPIO.
//   clk_in : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : rpi_irq_sched_if.slave (requests, ack pin, grant outputs)
// One interrupt is outstanding at a time; it ends on an ack rise or after
// TIMEOUT_CYC cycles, and is followed by HOLDOFF_CYC quiet cycles.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for sched_en and a pending request
// ST_GRANT   | one cycle, irq_id already latched, enable about to rise
// ST_ASSERT  | irq_enable high, waiting for ack rise or timeout
// ST_HOLDOFF | irq_enable low for HOLDOFF_CYC cycles before returning idle
module rpi_irq_sched
  import rpi_irq_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF
) (
  input logic           clk_in,
  input logic           rst_n,
  rpi_irq_sched_if.slave bus
);

  localparam int IDW = $clog2(N_SRC);
  localparam int CW  = $clog2(max_int(TIMEOUT_CYC, HOLDOFF_CYC) + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(HOLDOFF_CYC - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             irq_en_q;
  logic [IDW-1:0]   irq_id_q;
  logic [IDW-1:0]   last_grant_q;
  logic             busy_q;
  logic             err_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] ack_clr;
  logic [IDW-1:0]   rr_pick;
  logic [IDW-1:0]   rr_cand;
  logic             ack_rise;
  logic             acked;

  rpi_ack_sync u_ack_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .ack_i  (bus.rpi_ack),
    .rise_o (ack_rise)
  );

  // Ack rises outside ASSERT are dropped; a held-high pin never re-fires.
  assign acked = (state_q == ST_ASSERT) && ack_rise;

  // A new request in the same cycle as the ack keeps the flag set.
  always_comb begin
    ack_clr = '0;
    if (acked) ack_clr[irq_id_q] = 1'b1;
    pending_d = (pending_q & ~ack_clr) | bus.src_req;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Walk from farthest to nearest so the first pending source after
  // last_grant is the one left standing.
  always_comb begin
    rr_pick = last_grant_q;
    rr_cand = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      rr_cand = IDW'((int'(last_grant_q) + i) % N_SRC);
      if (pending_q[rr_cand]) rr_pick = rr_cand;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      irq_en_q     <= 1'b0;
      irq_id_q     <= '0;
      last_grant_q <= IDW'(N_SRC - 1);
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (bus.sched_en && (|pending_q)) begin
            state_q      <= ST_GRANT;
            irq_id_q     <= rr_pick;
            last_grant_q <= rr_pick;
            busy_q       <= 1'b1;
          end
        end
        ST_GRANT: begin
          state_q  <= ST_ASSERT;
          irq_en_q <= 1'b1;
          cnt_q    <= '0;
        end
        ST_ASSERT: begin
          if (acked) begin
            state_q  <= ST_HOLDOFF;
            irq_en_q <= 1'b0;
            cnt_q    <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q  <= ST_HOLDOFF;
            irq_en_q <= 1'b0;
            err_q    <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == HO_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          irq_en_q <= 1'b0;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.irq_enable = irq_en_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.pending    = pending_q;
  assign bus.busy       = busy_q;
  assign bus.err_pulse  = err_q;

endmodule
